// File: rtl/io_poll_hub.sv
// io_poll_hub: memory-mapped hub for RAM, switch data, polled debounced button channels and the seven-segment register
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   cpu_addr   CPU address; cpu_wdata / cpu_we / cpu_rd are the bus write data and strobes
//   cpu_rdata  combinational read data (RAM, I/O registers or DEFAULT_RDATA)
//   mem_we     RAM write enable for addresses 0..MEM_END
//   mem_rdata  RAM read data
//   buttons    raw asynchronous push buttons, active-high
//   seg_out    seven-segment display register
//   irq        registered OR of the ready flags enabled by the mask
module io_poll_hub #(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 12,
    parameter logic [ADDR_W-1:0] MEM_END       = 12'h1FF,
    parameter int                NUM_CH        = 4,
    parameter logic [ADDR_W-1:0] IO_BASE       = 12'h900,
    parameter logic [ADDR_W-1:0] SEG_ADDR      = 12'hB00,
    parameter int                DEBOUNCE_CYC  = 16,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = 16'hF345
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [NUM_CH-1:0] buttons,
    output logic [DATA_W-1:0] seg_out,
    output logic              irq
);
    localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;

    logic [NUM_CH-1:0] sync1_q, sync2_q, deb_q, deb_dly_q, ready_q, ovr_q, mask_q;
    logic [NUM_CH-1:0] deb_d, ready_d, ovr_d, mask_d, press, rd_data, rd_stat, live;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [DATA_W-1:0] ch_data_q [NUM_CH];
    logic [DATA_W-1:0] ch_data_d [NUM_CH];
    logic [DATA_W-1:0] swdata_q, swdata_d, seg_q, seg_d, summary;
    logic              irq_q, irq_d;
    logic [ADDR_W-1:0] off;
    logic              is_mem, is_seg, is_io;

    assign off    = cpu_addr - IO_BASE;
    assign is_mem = cpu_addr <= MEM_END;
    assign is_seg = !is_mem && cpu_addr == SEG_ADDR;
    assign is_io  = !is_mem && !is_seg && cpu_addr >= IO_BASE && off < ADDR_W'(2 + 2 * NUM_CH);
    assign mem_we  = cpu_we && is_mem;
    assign seg_out = seg_q;
    assign irq     = irq_q;
    // Edge of the debounced level, one cycle after it toggles
    assign press   = deb_q & ~deb_dly_q;

    always_comb begin
        deb_d    = deb_q;
        swdata_d = (cpu_we && is_io && off == '0) ? cpu_wdata : swdata_q;
        mask_d   = (cpu_we && is_io && off == ADDR_W'(1)) ? cpu_wdata[NUM_CH-1:0] : mask_q;
        seg_d    = (cpu_we && is_seg) ? cpu_wdata : seg_q;
        irq_d    = |(ready_q & mask_q);
        rd_data  = '0;
        rd_stat  = '0;
        live     = '0;
        ready_d  = '0;
        ovr_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) ? '0 : cnt_q[i] + 1'b1;
            if (sync2_q[i] != deb_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYC - 1))
                deb_d[i] = sync2_q[i];
            rd_data[i] = cpu_rd && is_io && off == ADDR_W'(2 + 2 * i);
            rd_stat[i] = cpu_rd && is_io && off == ADDR_W'(3 + 2 * i);
            // A same-cycle data read empties the slot first, so a coincident press captures instead of overrunning
            live[i]      = ready_q[i] && !rd_data[i];
            ch_data_d[i] = (press[i] && !live[i]) ? swdata_q : ch_data_q[i];
            ready_d[i]   = press[i] || live[i];
            ovr_d[i]     = (press[i] && live[i]) || (ovr_q[i] && !rd_stat[i]);
        end
    end

    always_comb begin
        summary = '0;
        summary[NUM_CH-1:0] = ready_q;
        summary[8 +: NUM_CH] = mask_q;
        cpu_rdata = DEFAULT_RDATA;
        if (is_mem)
            cpu_rdata = mem_rdata;
        else if (is_seg)
            cpu_rdata = seg_q;
        else if (is_io) begin
            cpu_rdata = (off == '0) ? swdata_q : summary;
            for (int i = 0; i < NUM_CH; i++) begin
                if (off == ADDR_W'(2 + 2 * i))
                    cpu_rdata = ch_data_q[i];
                if (off == ADDR_W'(3 + 2 * i))
                    cpu_rdata = {{(DATA_W-2){1'b0}}, ovr_q[i], ready_q[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            ready_q   <= '0;
            ovr_q     <= '0;
            mask_q    <= '0;
            swdata_q  <= DATA_W'(1);
            seg_q     <= DATA_W'(1);
            irq_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                ch_data_q[i] <= '0;
            end
        end else begin
            sync1_q   <= buttons;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            mask_q    <= mask_d;
            swdata_q  <= swdata_d;
            seg_q     <= seg_d;
            irq_q     <= irq_d;
            cnt_q     <= cnt_d;
            ch_data_q <= ch_data_d;
        end
    end
endmodule

// File: tb/tb_io_poll_hub.sv
// tb_io_poll_hub: directed scoreboard bench for io_poll_hub
module tb_io_poll_hub;
    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_rdata;
    logic        mem_we;
    logic [15:0] mem_rdata = 16'hBEEF;
    logic [3:0]  buttons = '0;
    logic [15:0] seg_out;
    logic        irq;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    io_poll_hub dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .buttons(buttons), .seg_out(seg_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [11:0] a, input string tag, input logic [15:0] v);
        push(tag, v);
        cpu_addr = a;
        cpu_rd = 1'b0;
        #1;
        check(cpu_rdata);
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [15:0] v);
        push(tag, v);
        cpu_addr = a;
        cpu_rd = 1'b1;
        #1;
        check(cpu_rdata);
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        cpu_addr = a;
        cpu_wdata = d;
        cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic press(input int ch);
        buttons[ch] = 1'b1;
        step(25);
        buttons[ch] = 1'b0;
        step(25);
    endtask

    initial begin
        // Reset, including a reset that aborts a debounce in progress
        step(3);
        rst_n = 1'b1;
        step(1);
        push("rst_seg", 16'h0001);
        check(seg_out);
        peek(12'h900, "rst_swdata", 16'h0001);
        peek(12'h901, "rst_summary", 16'h0000);
        push("rst_irq", 16'h0000);
        check({15'b0, irq});
        buttons[3] = 1'b1;
        step(10);
        rst_n = 1'b0;
        buttons[3] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(30);
        peek(12'h901, "abort_summary", 16'h0000);
        peek(12'h909, "abort_stat3", 16'h0000);
        peek(12'hB00, "rst_seg_read", 16'h0001);

        // Capture on channel 2 with exact latency
        wr(12'h900, 16'h00A5);
        buttons[2] = 1'b1;
        step(18);
        peek(12'h907, "lat_before", 16'h0000);
        step(1);
        peek(12'h907, "lat_at19", 16'h0001);
        step(21);
        buttons[2] = 1'b0;
        step(25);
        peek(12'h901, "cap_summary", 16'h0004);
        rd(12'h906, "cap_data", 16'h00A5);
        rd(12'h907, "cap_stat_clr", 16'h0000);

        // Bouncing input never settles long enough
        for (int i = 0; i < 12; i++) begin
            buttons[0] = ~buttons[0];
            step(5);
        end
        buttons[0] = 1'b0;
        step(30);
        peek(12'h901, "bounce_summary", 16'h0000);

        // Overrun keeps the oldest data
        wr(12'h900, 16'h0011);
        press(1);
        wr(12'h900, 16'h0022);
        press(1);
        peek(12'h904, "ovr_data_peek", 16'h0011);
        rd(12'h905, "ovr_stat", 16'h0003);
        rd(12'h905, "ovr_stat_clr", 16'h0001);
        rd(12'h904, "ovr_data", 16'h0011);
        peek(12'h901, "ovr_summary", 16'h0000);

        // Interrupt gated by the mask
        wr(12'h901, 16'h0002);
        peek(12'h901, "mask_summary", 16'h0200);
        press(0);
        push("irq_masked", 16'h0000);
        check({15'b0, irq});
        buttons[1] = 1'b1;
        step(19);
        push("irq_same_cycle", 16'h0000);
        check({15'b0, irq});
        peek(12'h901, "irq_summary", 16'h0203);
        step(1);
        push("irq_set", 16'h0001);
        check({15'b0, irq});
        buttons[1] = 1'b0;
        step(25);
        rd(12'h904, "irq_data", 16'h0022);
        push("irq_hold", 16'h0001);
        check({15'b0, irq});
        step(1);
        push("irq_clear", 16'h0000);
        check({15'b0, irq});
        rd(12'h902, "ch0_data", 16'h0022);

        // Address map
        cpu_addr = 12'h0A0;
        cpu_wdata = 16'h1234;
        cpu_we = 1'b1;
        #1;
        push("ram_we", 16'h0001);
        check({15'b0, mem_we});
        push("ram_rdata", 16'hBEEF);
        check(cpu_rdata);
        @(negedge clk);
        cpu_addr = 12'hB00;
        #1;
        push("seg_we", 16'h0000);
        check({15'b0, mem_we});
        @(negedge clk);
        cpu_we = 1'b0;
        push("seg_val", 16'h1234);
        check(seg_out);
        wr(12'h7FF, 16'h5555);
        peek(12'h7FF, "unmapped", 16'hF345);
        peek(12'h90A, "past_window", 16'hF345);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
